// File: rtl/img_pkg.sv
// Shared image-pipeline package: default geometry, 3x3 window element
// indices and a helper to pull one pixel out of a packed window.
package img_pkg;

    localparam int DEF_PIX_W      = 8;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    // Window element k = 3*r + c, r=0 oldest row, c=0 oldest column
    localparam int WIN_TL = 0;
    localparam int WIN_TM = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MM = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BM = 7;
    localparam int WIN_BR = 8;

    function automatic logic [DEF_PIX_W-1:0] win_elem(
        input logic [9*DEF_PIX_W-1:0] win,
        input int                     k
    );
        return win[DEF_PIX_W*k +: DEF_PIX_W];
    endfunction

endpackage

// File: rtl/sobel_window_gen_line_ram.sv
// Single-port read-before-write line memory. The address is driven from
// the column counter register, so the read reflects the contents before
// the write that happens on the same edge.
module line_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Store the new pixel; contents are never cleared since stale data is masked downstream
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel stage. Two line
// memories hold the previous two rows; three 3-tap shift registers build
// the window, which is flagged valid only when it lies fully in the image.
module sobel_window_gen
    import img_pkg::*;
#(
    parameter int PIX_W      = DEF_PIX_W,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pixel_in,
    input  logic               pixel_valid,
    input  logic               sof,
    output logic [9*PIX_W-1:0] window_out,
    output logic               window_valid,
    output logic [15:0]        center_row,
    output logic [15:0]        center_col
);

    localparam int          AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [15:0] COL_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(IMG_HEIGHT - 1);

    logic [15:0]      col;
    logic [15:0]      row;
    logic [15:0]      col_eff;
    logic [15:0]      row_eff;
    logic [AW-1:0]    ram_addr;
    logic [PIX_W-1:0] line0_rd;
    logic [PIX_W-1:0] line1_rd;
    logic [PIX_W-1:0] col_in [3];
    logic [PIX_W-1:0] win [3][3];
    logic             win_hit;

    // Position of the pixel on the bus: sof snaps it to (0,0) regardless of the counters
    always_comb begin
        col_eff = sof ? 16'd0 : col;
        row_eff = sof ? 16'd0 : row;
        win_hit = pixel_valid && (row_eff >= 16'd2) && (col_eff >= 16'd2);
    end

    assign ram_addr = col_eff[AW-1:0];

    // Raster counters: column wraps into the row, row wraps into the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pixel_valid) begin
            if (col_eff == COL_LAST) begin
                col <= '0;
                row <= (row_eff == ROW_LAST) ? 16'd0 : row_eff + 16'd1;
            end else begin
                col <= col_eff + 16'd1;
                row <= row_eff;
            end
        end
    end

    // line0 holds the previous row; its displaced pixel cascades into line1
    line_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W),
        .AW    (AW)
    ) u_line0 (
        .clk     (clk),
        .we      (pixel_valid),
        .addr    (ram_addr),
        .wr_data (pixel_in),
        .rd_data (line0_rd)
    );

    line_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W),
        .AW    (AW)
    ) u_line1 (
        .clk     (clk),
        .we      (pixel_valid),
        .addr    (ram_addr),
        .wr_data (line0_rd),
        .rd_data (line1_rd)
    );

    // Newest column entering the window: oldest row from line1, newest from the bus
    always_comb begin
        col_in[0] = line1_rd;
        col_in[1] = line0_rd;
        col_in[2] = pixel_in;
    end

    // Shift each row left by one column on every accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (pixel_valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
                win[r][2] <= col_in[r];
            end
        end
    end

    // Valid strobe and centre coordinates for the window just completed
    always_ff @(posedge clk) begin
        if (rst) begin
            window_valid <= 1'b0;
            center_row   <= '0;
            center_col   <= '0;
        end else begin
            window_valid <= win_hit;
            if (win_hit) begin
                center_row <= row_eff - 16'd1;
                center_col <= col_eff - 16'd1;
            end
        end
    end

    assign window_out[PIX_W*WIN_TL +: PIX_W] = win[0][0];
    assign window_out[PIX_W*WIN_TM +: PIX_W] = win[0][1];
    assign window_out[PIX_W*WIN_TR +: PIX_W] = win[0][2];
    assign window_out[PIX_W*WIN_ML +: PIX_W] = win[1][0];
    assign window_out[PIX_W*WIN_MM +: PIX_W] = win[1][1];
    assign window_out[PIX_W*WIN_MR +: PIX_W] = win[1][2];
    assign window_out[PIX_W*WIN_BL +: PIX_W] = win[2][0];
    assign window_out[PIX_W*WIN_BM +: PIX_W] = win[2][1];
    assign window_out[PIX_W*WIN_BR +: PIX_W] = win[2][2];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: a 4x4 instance for directed and random
// streams, and a 640x3 instance for the wide-row boundary. A frame-store
// model predicts every window straight from the pixels it has seen.
module tb_sobel_window_gen;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_valid, a_sof;
    logic [7:0]  a_pix;
    logic [71:0] a_win;
    logic        a_wvalid;
    logic [15:0] a_crow, a_ccol;

    logic        b_valid, b_sof;
    logic [7:0]  b_pix;
    logic [71:0] b_win;
    logic        b_wvalid;
    logic [15:0] b_crow, b_ccol;

    sobel_window_gen #(.PIX_W(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .pixel_in     (a_pix),
        .pixel_valid  (a_valid),
        .sof          (a_sof),
        .window_out   (a_win),
        .window_valid (a_wvalid),
        .center_row   (a_crow),
        .center_col   (a_ccol)
    );

    sobel_window_gen #(.PIX_W(8), .IMG_WIDTH(640), .IMG_HEIGHT(3)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .pixel_in     (b_pix),
        .pixel_valid  (b_valid),
        .sof          (b_sof),
        .window_out   (b_win),
        .window_valid (b_wvalid),
        .center_row   (b_crow),
        .center_col   (b_ccol)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;

    int          pr [2];
    int          pc [2];
    logic        expValid [2];
    logic [71:0] expWin [2];
    logic        winKnown [2];
    logic        centerKnown [2];
    logic [15:0] expRow [2];
    logic [15:0] expCol [2];
    logic [7:0]  fs [2][1920];
    int          nWin [2];
    logic [71:0] firstWin [2];
    logic [71:0] lastWin [2];

    function automatic int imgW(input int u);
        return (u == 0) ? 4 : 640;
    endfunction

    function automatic int imgH(input int u);
        return (u == 0) ? 4 : 3;
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Frame-store model: remember every pixel by image position, then a
    // window centred at (row-1,col-1) is simply the 3x3 block ending here
    task automatic modelStep(input int u, input logic r, input logic v, input logic s, input logic [7:0] p);
        if (r) begin
            pr[u] = 0;
            pc[u] = 0;
            expValid[u] = 1'b0;
            expWin[u] = '0;
            winKnown[u] = 1'b1;
            centerKnown[u] = 1'b1;
            expRow[u] = '0;
            expCol[u] = '0;
        end else if (v) begin
            if (s) begin
                pr[u] = 0;
                pc[u] = 0;
            end
            fs[u][pr[u]*imgW(u) + pc[u]] = p;
            if (pr[u] >= 2 && pc[u] >= 2) begin
                expValid[u] = 1'b1;
                for (int rr = 0; rr < 3; rr++) begin
                    for (int cc = 0; cc < 3; cc++) begin
                        expWin[u][8*(3*rr+cc) +: 8] = fs[u][(pr[u]-2+rr)*imgW(u) + pc[u]-2+cc];
                    end
                end
                winKnown[u] = 1'b1;
                centerKnown[u] = 1'b1;
                expRow[u] = 16'(pr[u] - 1);
                expCol[u] = 16'(pc[u] - 1);
            end else begin
                expValid[u] = 1'b0;
                winKnown[u] = 1'b0;
                centerKnown[u] = 1'b0;
            end
            pc[u]++;
            if (pc[u] == imgW(u)) begin
                pc[u] = 0;
                pr[u]++;
                if (pr[u] == imgH(u)) pr[u] = 0;
            end
        end else begin
            expValid[u] = 1'b0;
            centerKnown[u] = 1'b0;
        end
    endtask

    task automatic monitorCheck(input int u, input logic wv, input logic [71:0] w,
                                input logic [15:0] cr, input logic [15:0] cc);
        checkOutput($sformatf("valid_u%0d", u), {71'd0, wv}, {71'd0, expValid[u]});
        if (winKnown[u]) checkOutput($sformatf("window_u%0d", u), w, expWin[u]);
        if (centerKnown[u]) begin
            checkOutput($sformatf("center_row_u%0d", u), {56'd0, cr}, {56'd0, expRow[u]});
            checkOutput($sformatf("center_col_u%0d", u), {56'd0, cc}, {56'd0, expCol[u]});
        end
        if (wv) begin
            if (nWin[u] == 0) firstWin[u] = w;
            nWin[u]++;
            lastWin[u] = w;
        end
    endtask

    // Predict at the edge from the inputs it samples, compare just after it
    always @(posedge clk) begin
        modelStep(0, rst, a_valid, a_sof, a_pix);
        modelStep(1, rst, b_valid, b_sof, b_pix);
        #1;
        monitorCheck(0, a_wvalid, a_win, a_crow, a_ccol);
        monitorCheck(1, b_wvalid, b_win, b_crow, b_ccol);
    end

    task automatic applyStimulus(input int u, input logic v, input logic s, input logic [7:0] p);
        @(negedge clk);
        rst = 1'b0;
        a_valid = 1'b0; a_sof = 1'b0;
        b_valid = 1'b0; b_sof = 1'b0;
        if (u == 0) begin
            a_valid = v; a_sof = s; a_pix = p;
        end else begin
            b_valid = v; b_sof = s; b_pix = p;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic resetPulse();
        @(negedge clk);
        rst = 1'b1;
        a_valid = 1'b0; a_sof = 1'b0;
        b_valid = 1'b0; b_sof = 1'b0;
    endtask

    // Feed the first 'beats' pixels of a frame; instance 0 uses 16*row+col, instance 1 uses col[7:0]
    task automatic feedFrame(input int u, input int beats, input logic withSof, input logic stall);
        for (int i = 0; i < beats; i++) begin
            int row;
            int col;
            row = i / imgW(u);
            col = i % imgW(u);
            applyStimulus(u, 1'b1, withSof && (i == 0),
                          (u == 0) ? 8'(16*row + col) : 8'(col));
            if (stall) applyStimulus(u, 1'b0, 1'b0, 8'hEE);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_sof = 1'b0; a_pix = '0;
        b_valid = 1'b0; b_sof = 1'b0; b_pix = '0;
        nWin[0] = 0;
        nWin[1] = 0;
        repeat (2) @(negedge clk);
        idleCycles(2);

        $display("[TB] basic window");
        nWin[0] = 0;
        feedFrame(0, 16, 1'b1, 1'b0);
        idleCycles(2);
        checkOutput("basic_count", 72'(nWin[0]), 72'd4);
        checkOutput("basic_first", firstWin[0], 72'h22_21_20_12_11_10_02_01_00);
        checkOutput("basic_last", lastWin[0], 72'h33_32_31_23_22_21_13_12_11);

        $display("[TB] stall");
        nWin[0] = 0;
        feedFrame(0, 16, 1'b1, 1'b1);
        idleCycles(2);
        checkOutput("stall_count", 72'(nWin[0]), 72'd4);
        checkOutput("stall_first", firstWin[0], 72'h22_21_20_12_11_10_02_01_00);

        $display("[TB] back-to-back frames");
        nWin[0] = 0;
        feedFrame(0, 16, 1'b1, 1'b0);
        feedFrame(0, 16, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("b2b_count", 72'(nWin[0]), 72'd8);
        checkOutput("b2b_last", lastWin[0], 72'h33_32_31_23_22_21_13_12_11);

        $display("[TB] mid-row resync");
        nWin[0] = 0;
        feedFrame(0, 10, 1'b1, 1'b0);
        feedFrame(0, 16, 1'b1, 1'b0);
        idleCycles(2);
        checkOutput("resync_count", 72'(nWin[0]), 72'd4);
        checkOutput("resync_first", firstWin[0], 72'h22_21_20_12_11_10_02_01_00);

        $display("[TB] reset mid-frame");
        nWin[0] = 0;
        feedFrame(0, 9, 1'b1, 1'b0);
        resetPulse();
        feedFrame(0, 16, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("rst_count", 72'(nWin[0]), 72'd4);
        checkOutput("rst_first", firstWin[0], 72'h22_21_20_12_11_10_02_01_00);
        checkOutput("rst_last", lastWin[0], 72'h33_32_31_23_22_21_13_12_11);

        $display("[TB] random stream");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                resetPulse();
            end else begin
                applyStimulus(0, $urandom_range(0, 99) < 75, $urandom_range(0, 39) == 0, 8'($urandom));
            end
        end
        idleCycles(2);

        $display("[TB] width boundary");
        nWin[1] = 0;
        feedFrame(1, 640*3, 1'b1, 1'b0);
        idleCycles(2);
        checkOutput("wide_count", 72'(nWin[1]), 72'd638);
        checkOutput("wide_tr", {64'd0, lastWin[1][8*2 +: 8]}, 72'h7F);
        checkOutput("wide_mr", {64'd0, lastWin[1][8*5 +: 8]}, 72'h7F);
        checkOutput("wide_br", {64'd0, lastWin[1][8*8 +: 8]}, 72'h7F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
